// File: rtl/fetch_unit_if.sv
// Bundle of the instruction-memory port, the redirect input and the
// downstream instruction handshake seen by the fetch unit.
interface fetch_unit_if;
    // instruction memory request/response
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    // redirect from execute
    logic        redirect;
    logic [31:0] redirect_pc;
    // downstream (decode) handshake
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    // fetch unit side
    modport master (
        output imem_read, imem_address, inst_valid, inst_data, inst_pc,
        input  imem_rdata, imem_resp, redirect, redirect_pc, inst_ready
    );

    // environment side: memory, execute and decode
    modport slave (
        input  imem_read, imem_address, inst_valid, inst_data, inst_pc,
        output imem_rdata, imem_resp, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch controller: owns the fetch PC, issues one read at a
// time, buffers the returned word and offers it downstream. Redirects that
// arrive while a read is outstanding are parked until the response drains
// so the memory never sees the address move under an active request.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic        r_kill;     // outstanding response must be discarded
    logic [31:0] r_pend;     // redirect target parked while r_kill is set
    logic        r_gap;      // idle cycle after a discarded response
    logic [31:0] r_inst_data;
    logic [31:0] r_inst_pc;

    logic [31:0] w_tgt;
    logic        w_req;

    // Targets are word aligned; the low two bits of redirect_pc are dropped.
    assign w_tgt = bus.redirect_pc & ~32'd3;

    // A read is active in FETCH except for the one-cycle gap that separates
    // a discarded response from the next request.
    assign w_req = (r_state == S_FETCH) && !r_gap;

    assign bus.imem_read    = w_req;
    assign bus.imem_address = r_pc;
    assign bus.inst_valid   = (r_state == S_HOLD);
    assign bus.inst_data    = r_inst_data;
    assign bus.inst_pc      = r_inst_pc;

    // Fetch state machine, PC update and instruction buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_pend      <= 32'd0;
            r_gap       <= 1'b0;
            r_inst_data <= 32'd0;
            r_inst_pc   <= 32'd0;
        end else begin
            r_gap <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (r_gap) begin
                        // Nothing outstanding: a redirect can move the PC directly.
                        if (bus.redirect) r_pc <= w_tgt;
                    end else if (bus.imem_resp) begin
                        if (bus.redirect) begin
                            // Newest redirect wins over any parked target.
                            r_pc   <= w_tgt;
                            r_kill <= 1'b0;
                            r_gap  <= 1'b1;
                        end else if (r_kill) begin
                            r_pc   <= r_pend;
                            r_kill <= 1'b0;
                            r_gap  <= 1'b1;
                        end else begin
                            r_inst_data <= bus.imem_rdata;
                            r_inst_pc   <= r_pc;
                            r_pc        <= r_pc + 32'd4;
                            r_state     <= S_HOLD;
                        end
                    end else if (bus.redirect) begin
                        // Keep the address stable; apply the target after the drain.
                        r_kill <= 1'b1;
                        r_pend <= w_tgt;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect) begin
                        r_pc    <= w_tgt;
                        r_state <= S_FETCH;
                    end else if (bus.inst_ready) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Stimulus pushes expected request addresses
// and expected delivered instructions into queues; monitors pop and compare
// when the DUT starts a read or completes a downstream handshake.
module tb_fetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    logic clk;
    logic rst;
    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h4000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_req[$];
    inst_t       exp_inst[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request monitor: each new read must match the next expected address,
    // and the address must not move while the read stays high.
    logic        prev_read;
    logic [31:0] prev_addr;
    always @(negedge clk) begin
        if (rst) begin
            prev_read = 1'b0;
        end else begin
            if (bus.imem_read && !prev_read) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_request", bus.imem_address, 32'hxxxx_xxxx);
                end else begin
                    chk("request_addr", bus.imem_address, exp_req.pop_front());
                end
            end else if (bus.imem_read && prev_read) begin
                chk("addr_stable", bus.imem_address, prev_addr);
            end
            prev_read = bus.imem_read;
            prev_addr = bus.imem_address;
        end
    end

    // Instruction monitor: handshakes pop the scoreboard; a stalled
    // instruction must keep its data and pc.
    logic  held;
    inst_t held_v;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (bus.inst_valid) begin
            if (held) begin
                chk("inst_data_stable", bus.inst_data, held_v.data);
                chk("inst_pc_stable", bus.inst_pc, held_v.pc);
            end
            if (bus.inst_ready) begin
                if (exp_inst.size() == 0) begin
                    chk("unexpected_inst", bus.inst_pc, 32'hxxxx_xxxx);
                end else begin
                    held_v = exp_inst.pop_front();
                    chk("inst_pc", bus.inst_pc, held_v.pc);
                    chk("inst_data", bus.inst_data, held_v.data);
                end
                held = 1'b0;
            end else begin
                held = 1'b1;
                held_v.pc   = bus.inst_pc;
                held_v.data = bus.inst_data;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        rst              = 1'b1;
        bus.imem_rdata   = 32'd0;
        bus.imem_resp    = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'd0;
        bus.inst_ready   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        exp_req.push_back(32'h4000_0000);
        rst = 1'b0;

        // First fetch: three wait cycles, then response
        chk("first_read", {31'd0, bus.imem_read}, 32'd1);
        repeat (3) step();
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        exp_inst.push_back('{pc: 32'h4000_0000, data: 32'h0000_0013});
        exp_req.push_back(32'h4000_0004);
        step();
        bus.imem_resp = 1'b0;
        chk("resp_to_valid", {31'd0, bus.inst_valid}, 32'd1);

        // Stall in HOLD for five cycles
        for (int i = 0; i < 5; i++) begin
            chk("hold_no_read", {31'd0, bus.imem_read}, 32'd0);
            step();
        end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;

        // Redirect mid-request; address held until the killed response
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h4000_0103;
        step();
        bus.redirect = 1'b0;
        step();
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        exp_req.push_back(32'h4000_0100);
        step();
        bus.imem_resp = 1'b0;
        chk("kill_gap_read", {31'd0, bus.imem_read}, 32'd0);
        chk("kill_no_valid", {31'd0, bus.inst_valid}, 32'd0);
        step();

        // Redirect in the same cycle as the response
        step();
        bus.imem_resp   = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h4000_0200;
        exp_req.push_back(32'h4000_0200);
        step();
        bus.imem_resp = 1'b0;
        bus.redirect  = 1'b0;
        chk("same_cycle_gap_read", {31'd0, bus.imem_read}, 32'd0);
        chk("same_cycle_no_valid", {31'd0, bus.inst_valid}, 32'd0);
        step();
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'h0000_AAAA;
        exp_inst.push_back('{pc: 32'h4000_0200, data: 32'h0000_AAAA});
        step();
        bus.imem_resp = 1'b0;

        // Redirect in HOLD together with inst_ready
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        exp_req.push_back(32'hFFFF_FFFC);
        step();
        bus.inst_ready = 1'b0;
        bus.redirect   = 1'b0;
        chk("hold_redirect_valid", {31'd0, bus.inst_valid}, 32'd0);

        // PC wrap at the top of the address space
        step();
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'h0000_1234;
        exp_inst.push_back('{pc: 32'hFFFF_FFFC, data: 32'h0000_1234});
        exp_req.push_back(32'h0000_0000);
        step();
        bus.imem_resp = 1'b0;
        chk("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("wrap_addr", bus.imem_address, 32'h0000_0000);

        // Reset in the middle of a request
        step();
        rst = 1'b1;
        exp_req.push_back(32'h4000_0000);
        step();
        step();
        rst = 1'b0;
        chk("post_rst_addr", bus.imem_address, 32'h4000_0000);
        chk("post_rst_read", {31'd0, bus.imem_read}, 32'd1);
        step();
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'h0000_0077;
        exp_inst.push_back('{pc: 32'h4000_0000, data: 32'h0000_0077});
        exp_req.push_back(32'h4000_0004);
        step();
        bus.imem_resp  = 1'b0;
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        step();
        step();

        chk("req_queue_drained", exp_req.size(), 32'd0);
        chk("inst_queue_drained", exp_inst.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
